// File: rtl/pulse_pacer.sv
// clk_a-domain event pacer: buffers event requests and re-emits them as single-cycle
// pulses spaced at least MIN_GAP cycles apart for a downstream pulse CDC stage.
module pulse_pacer #(
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = 8
) (
  input  logic             clk_a,
  input  logic             rst_n,
  input  logic             event_in,
  input  logic             enable,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  // gap_cnt must hold MIN_GAP-2; keep at least one bit for MIN_GAP==2
  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             fire;
  logic             drop;

  // fire and drop decisions use the pre-edge pending value
  assign fire = (state == IDLE) && enable && (pending != '0);
  assign drop = event_in && !fire && (pending == CNT_MAX);

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      pulse_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            pulse_out <= 1'b1;
            state     <= GAP;
            gap_cnt   <= GAP_LOAD;
          end else begin
            pulse_out <= 1'b0;
          end
        end
        GAP: begin
          pulse_out <= 1'b0;
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          pulse_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (event_in && !fire && (pending != CNT_MAX)) begin
      pending <= pending + 1'b1;
    end else if (!event_in && fire) begin
      pending <= pending - 1'b1;
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer: two instances (CNT_W=4 and CNT_W=2) checked every
// cycle against an edge-numbered behavioural model, plus hand-computed literal checks.
module tb_pulse_pacer;

  localparam int MIN_GAP = 8;

  logic clk_a = 1'b0;
  logic rst_n = 1'b1;
  logic event_in = 1'b0;
  logic enable = 1'b0;
  logic clr_ovf = 1'b0;

  logic       pulse_a, busy_a, ovf_a;
  logic [3:0] pend_a;
  logic       pulse_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  int ntests = 0;
  int nfail  = 0;
  bit chk    = 1'b0;

  pulse_pacer #(.CNT_W(4), .MIN_GAP(MIN_GAP)) dut_a (
    .clk_a(clk_a), .rst_n(rst_n), .event_in(event_in), .enable(enable),
    .clr_ovf(clr_ovf), .pulse_out(pulse_a), .pending(pend_a), .busy(busy_a),
    .overflow(ovf_a)
  );

  pulse_pacer #(.CNT_W(2), .MIN_GAP(MIN_GAP)) dut_b (
    .clk_a(clk_a), .rst_n(rst_n), .event_in(event_in), .enable(enable),
    .clr_ovf(clr_ovf), .pulse_out(pulse_b), .pending(pend_b), .busy(busy_b),
    .overflow(ovf_b)
  );

  always #5 clk_a = ~clk_a;

  // Model: cyc is the number of the next clock edge; m_last is the edge of the last pulse.
  int cyc       = 0;
  int m_pend[2] = '{0, 0};
  bit m_ovf[2]  = '{1'b0, 1'b0};
  int m_last[2] = '{-1000, -1000};
  bit m_pulse[2] = '{1'b0, 1'b0};
  int maxv[2]   = '{15, 3};

  function automatic bit m_fire(int k);
    return enable && (m_pend[k] != 0) && (cyc - m_last[k] >= MIN_GAP);
  endfunction

  function automatic bit m_busy(int k);
    return (m_pend[k] != 0) || (cyc - 1 - m_last[k] < MIN_GAP - 1);
  endfunction

  always @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k]  <= 0;
        m_ovf[k]   <= 1'b0;
        m_last[k]  <= -1000;
        m_pulse[k] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        m_pulse[k] <= m_fire(k);
        if (m_fire(k)) m_last[k] <= cyc;
        if (event_in && !m_fire(k)) begin
          if (m_pend[k] < maxv[k]) m_pend[k] <= m_pend[k] + 1;
          else m_ovf[k] <= 1'b1;
        end else if (!event_in && m_fire(k)) begin
          m_pend[k] <= m_pend[k] - 1;
        end
        if (clr_ovf && !(event_in && !m_fire(k) && m_pend[k] == maxv[k])) m_ovf[k] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_a) begin
    if (chk) begin
      check("pulse_a", 32'(pulse_a), 32'(m_pulse[0]));
      check("pend_a",  32'(pend_a),  32'(m_pend[0]));
      check("busy_a",  32'(busy_a),  32'(m_busy(0)));
      check("ovf_a",   32'(ovf_a),   32'(m_ovf[0]));
      check("pulse_b", 32'(pulse_b), 32'(m_pulse[1]));
      check("pend_b",  32'(pend_b),  32'(m_pend[1]));
      check("busy_b",  32'(busy_b),  32'(m_busy(1)));
      check("ovf_b",   32'(ovf_b),   32'(m_ovf[1]));
    end
  end

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pulse"}, 32'(pulse_a), 0);
    check({tag, "_pend"},  32'(pend_a),  0);
    check({tag, "_busy"},  32'(busy_a),  0);
    check({tag, "_ovf"},   32'(ovf_a),   0);
    check({tag, "_pend_b"}, 32'(pend_b), 0);
  endtask

  // Event at edge E: pending=1 after E, pulse only after E+1, busy clears after E+8.
  task automatic single_event(input string tag);
    event_in = 1'b1;
    tick();
    check({tag, "_pend_e0"}, 32'(pend_a), 1);
    check({tag, "_pulse_e0"}, 32'(pulse_a), 0);
    event_in = 1'b0;
    tick();
    check({tag, "_pulse_e1"}, 32'(pulse_a), 1);
    check({tag, "_pend_e1"}, 32'(pend_a), 0);
    tick();
    check({tag, "_pulse_e2"}, 32'(pulse_a), 0);
    repeat (5) tick();
    check({tag, "_busy_e7"}, 32'(busy_a), 1);
    tick();
    check({tag, "_busy_e8"}, 32'(busy_a), 0);
  endtask

  initial begin
    int pe[$];

    // Reset held under random inputs
    #2 rst_n = 1'b0;
    chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      event_in = 1'($urandom_range(0, 1));
      enable   = 1'($urandom_range(0, 1));
      clr_ovf  = 1'($urandom_range(0, 1));
      tick();
      check_cleared("rst");
    end
    event_in = 1'b0;
    enable   = 1'b1;
    clr_ovf  = 1'b0;
    rst_n    = 1'b1;
    tick();
    tick();

    single_event("single");

    // Burst of three events; the middle one coincides with a fire
    event_in = 1'b1;
    tick();
    check("burst_pend0", 32'(pend_a), 1);
    tick();
    check("burst_pend1", 32'(pend_a), 1);
    check("burst_pulse1", 32'(pulse_a), 1);
    tick();
    check("burst_pend2", 32'(pend_a), 2);
    event_in = 1'b0;
    pe.delete();
    for (int i = 3; i <= 30; i++) begin
      tick();
      if (pulse_a) pe.push_back(i);
    end
    check("burst_npulse", 32'(pe.size()), 2);
    if (pe.size() == 2) begin
      check("burst_edge2", 32'(pe[0]), 9);
      check("burst_edge3", 32'(pe[1]), 17);
    end
    check("burst_drained", 32'(pend_a), 0);

    // Saturation with enable low
    enable   = 1'b0;
    event_in = 1'b1;
    repeat (5) tick();
    check("sat_pend_b", 32'(pend_b), 3);
    check("sat_ovf_b",  32'(ovf_b),  1);
    check("sat_pend_a", 32'(pend_a), 5);
    check("sat_ovf_a",  32'(ovf_a),  0);
    clr_ovf = 1'b1;
    tick();
    check("setclr_ovf_b",  32'(ovf_b),  1);
    check("setclr_pend_b", 32'(pend_b), 3);
    check("setclr_pend_a", 32'(pend_a), 6);
    event_in = 1'b0;
    tick();
    check("clr_ovf_b", 32'(ovf_b), 0);
    clr_ovf = 1'b0;
    enable  = 1'b1;
    pe.delete();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pulse_b) pe.push_back(i);
    end
    check("sat_npulse_b", 32'(pe.size()), 3);
    if (pe.size() == 3) begin
      check("sat_first_b", 32'(pe[0]), 1);
      check("sat_gap1_b", 32'(pe[1] - pe[0]), 8);
      check("sat_gap2_b", 32'(pe[2] - pe[1]), 8);
    end
    check("sat_drain_b", 32'(pend_b), 0);
    repeat (50) tick();
    check("sat_drain_a", 32'(pend_a), 0);

    // Reset asserted mid-GAP with two events still pending
    event_in = 1'b1;
    repeat (3) tick();
    event_in = 1'b0;
    check("midgap_pend", 32'(pend_a), 2);
    tick();
    check("midgap_busy", 32'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    single_event("after_rst");
    repeat (4) tick();

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
